seg7_scan_driver: RTL
=====================

Name: seg7_scan_driver

Overview:
- Downstream consumer of the system controller's display registers: Digits_Reg (8 bytes), CharEns_Reg (per-digit ASCII select and blink enable) and Enables_Reg (per-digit enable).
- Time-multiplexes an 8-digit common-anode seven-segment display with a blanking interval between digits to suppress ghosting.
- Decodes each byte as a hex nibble or an ASCII character, and applies per-digit blinking.
- Captures the three register inputs into shadow copies once per frame so the display never tears.

Parameters:
- DIGIT_PERIOD_CYCLES, 50000, total clocks per digit slot (BLANK plus DRIVE); must be >= BLANK_CYCLES+2.
- BLANK_CYCLES, 500, clocks with all anodes off at the start of each slot; must be >= 1.
- BLINK_FRAMES, 64, frames per blink half-period.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_digits  in  64  Digits_Reg; byte k ([8k+7:8k]) drives digit k, digit 0 rightmost.
- i_char_ens  in  16  CharEns_Reg; bit k=1 selects ASCII decode for digit k; bit 8+k=1 enables blink for digit k.
- i_enables  in  8  Enables_Reg; bit k=1 enables digit k.
- o_an  out  8  anodes, active low.
- o_seg  out  7  segments, active low; bit0=a … bit6=g.
- o_dp  out  1  decimal point, active low.
- o_frame_tick  out  1  one-cycle pulse at each frame start.

Behaviour:
- Reset (async assert, sync release) sets:
  - o_an=8'hFF, o_seg=7'h7F, o_dp=1, o_frame_tick=0.
  - state=BLANK, digit index idx=0, slot counter 0, frame counter 0, blink phase 0 (visible).
  - shadow registers 0.
- FSM, two states:
  - BLANK: o_an=FF, o_seg=7F, o_dp=1 for BLANK_CYCLES clocks, then go to DRIVE.
  - DRIVE: lasts DIGIT_PERIOD_CYCLES-BLANK_CYCLES clocks, then idx=(idx+1) mod 8 and go to BLANK.
- Frame start is the edge BLANK→DRIVE with idx=0, including the first one after reset. On that edge:
  - shadows load from i_digits, i_char_ens and i_enables.
  - o_frame_tick=1 for that cycle.
  - frame counter increments. When it wraps from BLINK_FRAMES-1 to 0, blink phase toggles.
  - the displayed digit-0 value uses the newly captured data.
- All outputs are registered. o_an, o_seg and o_dp change together on the edge entering DRIVE and return to off on the edge entering BLANK.
- In DRIVE, digit idx is lit (o_an = ~(8'h01<<idx)) only when shadow_en[idx]=1 and not (shadow_blink[idx] & phase=1). Otherwise all outputs stay off for that slot.
- Decode, with byte b=shadow byte idx. Patterns are given as gfedcba hex; o_seg = ~pattern.
  - Hex mode (ASCII bit=0): decode b[3:0]; o_dp=~b[7].
    - Patterns: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
  - ASCII mode: o_dp=1.
    - Digits '0'–'9' use the hex table.
    - Letters are case-insensitive: A77 B7C C39 D5E E79 F71 G3D H76 I06 J1E K75 L38 M37 N54 O3F P73 Q67 R50 S6D T78 U3E V1C W2A X76 Y6E Z5B.
    - Symbols: '-'=40, '_'=08, all other codes 00 (blank).
- Input changes mid-frame have no visible effect until the next frame start.
- Asynchronous reset during any state forces the reset values immediately, without waiting for a clock edge.

Test Plan:
Bench parameters: DIGIT_PERIOD_CYCLES=10, BLANK_CYCLES=2, BLINK_FRAMES=2.
- Reset/scan:
  - Stimulus: i_enables=FF, release reset.
  - Required: o_an=FF for 2 cycles, then FE for 8 cycles, FF for 2, FD for 8, … up to 7F.
  - Required: o_frame_tick pulses on the same edge as each FE, every 80 cycles.
- Hex decode:
  - Stimulus: i_char_ens=0, byte0=8'h88.
  - Required: digit 0 shows o_seg=7'h00, o_dp=0.
  - Stimulus: byte1=8'h0A.
  - Required: digit 1 shows o_seg=7'h08, o_dp=1.
- ASCII decode:
  - Stimulus: i_char_ens[0]=1, byte0=8'h48 ('H').
  - Required: o_seg=7'h09.
  - Stimulus: byte0=8'h68 ('h').
  - Required: o_seg=7'h09.
  - Stimulus: byte0=8'h3F ('?').
  - Required: o_seg=7'h7F, o_dp=1.
- Shadowing:
  - Stimulus: change byte0 from 8'h01 to 8'h02 while digit 3 is in DRIVE.
  - Required: digit 0 keeps o_seg=7'h79 for the rest of that frame; it shows 7'h24 only from the next o_frame_tick onward.
- Enable/blink:
  - Stimulus: i_enables=8'hF7.
  - Required: o_an[3] never low.
  - Stimulus: additionally i_char_ens[8]=1.
  - Required: o_an[0] goes low in frames 0–1, stays high in frames 2–3, then repeats; other digits are unaffected.
- Async reset:
  - Stimulus: assert i_rst_n=0 mid-DRIVE, between clock edges.
  - Required: o_an=FF, o_seg=7F, o_dp=1 immediately; after release, scan restarts with 2 blank cycles, then FE.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Eight-digit common-anode seven-segment scan driver with per-slot blanking,
// hex/ASCII glyph decode, per-digit blink and once-per-frame register shadowing.
//
// state    | meaning
// ST_BLANK | all anodes off for BLANK_CYCLES clocks to suppress ghosting
// ST_DRIVE | digit idx lit (if enabled and not blinked off) for the rest of the slot
module seg7_scan_driver #(
    parameter int DIGIT_PERIOD_CYCLES = 50000,
    parameter int BLANK_CYCLES        = 500,
    parameter int BLINK_FRAMES        = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [63:0] i_digits,
    input  logic [15:0] i_char_ens,
    input  logic [7:0]  i_enables,
    output logic [7:0]  o_an,
    output logic [6:0]  o_seg,
    output logic        o_dp,
    output logic        o_frame_tick
);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    localparam int CW = $clog2(DIGIT_PERIOD_CYCLES);
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DRIVE_LAST = CW'(DIGIT_PERIOD_CYCLES - BLANK_CYCLES - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [0:0]    state;
    logic [CW-1:0] slot_cnt;
    logic [2:0]    idx;
    logic [FW-1:0] frame_cnt;
    logic          blink_phase;
    logic          frame_phase;
    logic [63:0]   sh_digits;
    logic [15:0]   sh_char_ens;
    logic [7:0]    sh_enables;

    logic          blank_done;
    logic          drive_done;
    logic          frame_start;
    logic [63:0]   cur_digits;
    logic [15:0]   cur_char_ens;
    logic [7:0]    cur_enables;
    logic          cur_phase;
    logic [7:0]    cur_byte;
    logic          ascii_sel;
    logic          blink_sel;
    logic          lit;
    logic [6:0]    glyph;
    logic          dp_n;

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        logic [6:0] g;
        g = 7'h00;
        case (n)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            4'hF: g = 7'h71;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    function automatic logic [6:0] letter_glyph(input logic [4:0] n);
        logic [6:0] g;
        g = 7'h00;
        case (n)
            5'd0:  g = 7'h77;
            5'd1:  g = 7'h7C;
            5'd2:  g = 7'h39;
            5'd3:  g = 7'h5E;
            5'd4:  g = 7'h79;
            5'd5:  g = 7'h71;
            5'd6:  g = 7'h3D;
            5'd7:  g = 7'h76;
            5'd8:  g = 7'h06;
            5'd9:  g = 7'h1E;
            5'd10: g = 7'h75;
            5'd11: g = 7'h38;
            5'd12: g = 7'h37;
            5'd13: g = 7'h54;
            5'd14: g = 7'h3F;
            5'd15: g = 7'h73;
            5'd16: g = 7'h67;
            5'd17: g = 7'h50;
            5'd18: g = 7'h6D;
            5'd19: g = 7'h78;
            5'd20: g = 7'h3E;
            5'd21: g = 7'h1C;
            5'd22: g = 7'h2A;
            5'd23: g = 7'h76;
            5'd24: g = 7'h6E;
            5'd25: g = 7'h5B;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    // Setting bit 5 folds upper-case letters onto lower-case for the range test.
    function automatic logic [6:0] ascii_glyph(input logic [7:0] c);
        logic [7:0] lc;
        logic [7:0] ofs;
        logic [6:0] g;
        g   = 7'h00;
        lc  = c | 8'h20;
        ofs = lc - 8'h61;
        if (c >= 8'h30 && c <= 8'h39)
            g = hex_glyph(c[3:0]);
        else if (lc >= 8'h61 && lc <= 8'h7A)
            g = letter_glyph(ofs[4:0]);
        else if (c == 8'h2D)
            g = 7'h40;
        else if (c == 8'h5F)
            g = 7'h08;
        return g;
    endfunction

    assign blank_done  = (state == ST_BLANK) && (slot_cnt == BLANK_LAST);
    assign drive_done  = (state == ST_DRIVE) && (slot_cnt == DRIVE_LAST);
    assign frame_start = blank_done && (idx == 3'd0);

    // Digit 0 of a new frame must already show the freshly captured registers.
    assign cur_digits   = frame_start ? i_digits    : sh_digits;
    assign cur_char_ens = frame_start ? i_char_ens  : sh_char_ens;
    assign cur_enables  = frame_start ? i_enables   : sh_enables;
    assign cur_phase    = frame_start ? blink_phase : frame_phase;

    assign cur_byte  = cur_digits[{idx, 3'b000} +: 8];
    assign ascii_sel = cur_char_ens[{1'b0, idx}];
    assign blink_sel = cur_char_ens[{1'b1, idx}];
    assign lit       = cur_enables[idx] & ~(blink_sel & cur_phase);
    assign glyph     = ascii_sel ? ascii_glyph(cur_byte) : hex_glyph(cur_byte[3:0]);
    assign dp_n      = ascii_sel ? 1'b1 : ~cur_byte[7];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_BLANK;
            slot_cnt     <= '0;
            idx          <= 3'd0;
            frame_cnt    <= '0;
            blink_phase  <= 1'b0;
            frame_phase  <= 1'b0;
            sh_digits    <= '0;
            sh_char_ens  <= '0;
            sh_enables   <= '0;
            o_an         <= 8'hFF;
            o_seg        <= 7'h7F;
            o_dp         <= 1'b1;
            o_frame_tick <= 1'b0;
        end else begin
            o_frame_tick <= frame_start;
            case (state)
                ST_BLANK: begin
                    if (blank_done) begin
                        state    <= ST_DRIVE;
                        slot_cnt <= '0;
                        if (lit) begin
                            o_an  <= ~(8'h01 << idx);
                            o_seg <= ~glyph;
                            o_dp  <= dp_n;
                        end else begin
                            o_an  <= 8'hFF;
                            o_seg <= 7'h7F;
                            o_dp  <= 1'b1;
                        end
                    end else begin
                        slot_cnt <= slot_cnt + CW'(1);
                    end
                end
                default: begin
                    if (drive_done) begin
                        state    <= ST_BLANK;
                        slot_cnt <= '0;
                        idx      <= idx + 3'd1;
                        o_an     <= 8'hFF;
                        o_seg    <= 7'h7F;
                        o_dp     <= 1'b1;
                    end else begin
                        slot_cnt <= slot_cnt + CW'(1);
                    end
                end
            endcase

            // The phase toggled here applies from the following frame onward.
            if (frame_start) begin
                sh_digits   <= i_digits;
                sh_char_ens <= i_char_ens;
                sh_enables  <= i_enables;
                frame_phase <= blink_phase;
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end
        end
    end

endmodule
